signal_monitor: RTL and testbench

Passive checker on the 2-bit traffic-light signal bus. It sits beside the signal controller and consumes the `signal` output that the controller drives. It verifies the encoding, the phase order RED→YELLOW→GREEN→RED and the per-phase dwell time in clock cycles. The first violation is latched as a sticky fault with a code, for use by a supervisor or a failsafe flasher.

---
 rtl/signal_pkg.sv | 38 +++
 rtl/signal_monitor_if.sv | 38 +++
 rtl/sigmon_dwell_ctr.sv | 55 +++++
 rtl/signal_monitor.sv | 167 ++++++++++++++++
 tb/tb_signal_monitor.sv | 336 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/signal_pkg.sv
// Shared definitions for the traffic-light signal bus.
// Imported by the signal controller and by signal_monitor.
package signal_pkg;

  // Encoding of the 2-bit signal bus; SIG_ILL never appears on a healthy bus.
  typedef enum logic [1:0] {
    RED     = 2'b00,
    YELLOW  = 2'b01,
    GREEN   = 2'b10,
    SIG_ILL = 2'b11
  } sig_t;

  typedef enum logic [2:0] {
    FC_NONE       = 3'd0,
    FC_ENCODING   = 3'd1,
    FC_TRANSITION = 3'd2,
    FC_SHORT      = 3'd3,
    FC_LONG       = 3'd4
  } fault_code_t;

  typedef enum logic [1:0] {
    ST_ACQ   = 2'd0,
    ST_TRACK = 2'd1,
    ST_FAULT = 2'd2
  } mon_state_t;

  // Legal successor in the RED -> YELLOW -> GREEN -> RED cycle.
  // SIG_ILL has no successor; mapping it to itself means nothing can follow it.
  function automatic sig_t next_sig(input sig_t s);
    case (s)
      RED:     return YELLOW;
      YELLOW:  return GREEN;
      GREEN:   return RED;
      default: return SIG_ILL;
    endcase
  endfunction

endpackage

// File: rtl/signal_monitor_if.sv
// Bus between the signal controller side (master) and signal_monitor (slave).
// Optional build macro: SIGMON_STATS_EN adds cycle_done / cycle_cnt.
interface signal_monitor_if;

  logic [1:0]  signal;
  logic        clr;
  logic        locked;
  logic [1:0]  phase;
  logic        fault;
  logic [2:0]  fault_code;
`ifdef SIGMON_STATS_EN
  logic        cycle_done;
  logic [15:0] cycle_cnt;
`endif

`ifdef SIGMON_STATS_EN
  modport master (
    output signal, clr,
    input  locked, phase, fault, fault_code, cycle_done, cycle_cnt
  );

  modport slave (
    input  signal, clr,
    output locked, phase, fault, fault_code, cycle_done, cycle_cnt
  );
`else
  modport master (
    output signal, clr,
    input  locked, phase, fault, fault_code
  );

  modport slave (
    input  signal, clr,
    output locked, phase, fault, fault_code
  );
`endif

endinterface

// File: rtl/sigmon_dwell_ctr.sv
// Dwell counter for signal_monitor: counts consecutive edges that sampled the
// same value, restarting at 1 on a change (or clear), saturating at all-ones.
// Compare flags are evaluated against the limits of the phase held in ph.
module sigmon_dwell_ctr
  import signal_pkg::*;
#(
  parameter int MIN_DWELL = 6,
  parameter int MAX_DWELL = 12,
  parameter int YEL_MIN   = 1,
  parameter int YEL_MAX   = 3,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  sig_t             ph,
  output logic [CNT_W-1:0] cnt,
  output logic             below_min,
  output logic             at_max
);

  logic [CNT_W:0] cnt_inc;
  logic [CNT_W:0] ph_min;
  logic [CNT_W:0] ph_max;

  // Per-phase limits: YELLOW has its own window, RED/GREEN share one.
  always_comb begin
    ph_min = (CNT_W+1)'(MIN_DWELL);
    ph_max = (CNT_W+1)'(MAX_DWELL);
    if (ph == YELLOW) begin
      ph_min = (CNT_W+1)'(YEL_MIN);
      ph_max = (CNT_W+1)'(YEL_MAX);
    end
  end

  // Extra top bit of cnt_inc doubles as the saturation detect.
  assign cnt_inc   = {1'b0, cnt} + (CNT_W+1)'(1);
  // cnt is the completed dwell of ph when the bus changes on this edge.
  assign below_min = ({1'b0, cnt} < ph_min);
  // cnt_inc is the dwell including this edge; reaching the limit times out
  // without waiting for a change.
  assign at_max    = (cnt_inc == ph_max);

  // Load-1 on change/clear, otherwise increment and hold at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= CNT_W'(1);
    end else if (load) begin
      cnt <= CNT_W'(1);
    end else if (!cnt_inc[CNT_W]) begin
      cnt <= cnt_inc[CNT_W-1:0];
    end
  end

endmodule

// File: rtl/signal_monitor.sv
// Passive checker for the traffic-light signal bus: encoding, phase order and
// per-phase dwell. The first violation is latched as a sticky fault code.
// Optional build macro: SIGMON_STATS_EN adds a completed-cycle pulse/counter.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_ACQ   | after reset/clr; encoding checked, waiting for a legal change
// ST_TRACK | locked; encoding, order and dwell all checked
// ST_FAULT | sticky fault; code frozen until clr
module signal_monitor
  import signal_pkg::*;
#(
  parameter int MIN_DWELL = 6,
  parameter int MAX_DWELL = 12,
  parameter int YEL_MIN   = 1,
  parameter int YEL_MAX   = 3,
  parameter int CNT_W     = 8   // must hold MAX_DWELL+1
) (
  input logic              clk,
  input logic              rst_n,
  signal_monitor_if.slave  mon
);

  sig_t             samp;
  sig_t             prev_q;
  logic [1:0]       phase_q;
  mon_state_t       state_q;
  mon_state_t       state_d;
  fault_code_t      code_q;
  fault_code_t      code_d;
  fault_code_t      viol;
  logic             changed;
  logic             succ_ok;
  logic             below_min;
  logic             at_max;
  logic [CNT_W-1:0] dwell_cnt;
  logic             unused_cnt;

  assign samp    = sig_t'(mon.signal);
  assign changed = (samp != prev_q);
  assign succ_ok = (samp == next_sig(prev_q));

  sigmon_dwell_ctr #(
    .MIN_DWELL (MIN_DWELL),
    .MAX_DWELL (MAX_DWELL),
    .YEL_MIN   (YEL_MIN),
    .YEL_MAX   (YEL_MAX),
    .CNT_W     (CNT_W)
  ) u_dwell (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (changed | mon.clr),
    .ph        (prev_q),
    .cnt       (dwell_cnt),
    .below_min (below_min),
    .at_max    (at_max)
  );

  // The raw count is only consumed through the compare flags; it stays on the
  // sub-module boundary for debug probing.
  assign unused_cnt = ^dwell_cnt;

  // Bus sampler: prev always follows the bus, phase only takes legal values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q  <= RED;
      phase_q <= 2'b00;
    end else begin
      prev_q <= samp;
      if (samp != SIG_ILL) begin
        phase_q <= samp;
      end
    end
  end

  // Violation classification; the if-chain order gives lowest-code priority.
  always_comb begin
    viol = FC_NONE;
    if (samp == SIG_ILL) begin
      viol = FC_ENCODING;
    end else if (state_q == ST_TRACK) begin
      if (changed && !succ_ok) begin
        viol = FC_TRANSITION;
      end else if (changed && below_min) begin
        viol = FC_SHORT;
      end else if (!changed && at_max) begin
        viol = FC_LONG;
      end
    end
  end

  // Next-state and fault-code logic; clr overrides any coincident violation.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    if (mon.clr) begin
      state_d = ST_ACQ;
      code_d  = FC_NONE;
    end else begin
      case (state_q)
        ST_ACQ: begin
          if (viol != FC_NONE) begin
            state_d = ST_FAULT;
            code_d  = viol;
          end else if (changed && succ_ok) begin
            state_d = ST_TRACK;
          end
        end
        ST_TRACK: begin
          if (viol != FC_NONE) begin
            state_d = ST_FAULT;
            code_d  = viol;
          end
        end
        ST_FAULT: begin
          state_d = ST_FAULT;
        end
        default: begin
          state_d = ST_ACQ;
          code_d  = FC_NONE;
        end
      endcase
    end
  end

  // FSM state and latched fault code.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ACQ;
      code_q  <= FC_NONE;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
    end
  end

  assign mon.locked     = (state_q == ST_TRACK);
  assign mon.fault      = (state_q == ST_FAULT);
  assign mon.fault_code = code_q;
  assign mon.phase      = phase_q;

`ifdef SIGMON_STATS_EN
  logic        accept_cycle;
  logic        cycle_done_q;
  logic [15:0] cycle_cnt_q;

  assign accept_cycle = !mon.clr && (state_q == ST_TRACK) && (viol == FC_NONE)
                        && (prev_q == GREEN) && (samp == RED);

  // Completed-cycle statistics; only rst_n clears them, clr leaves them alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_done_q <= 1'b0;
      cycle_cnt_q  <= 16'd0;
    end else begin
      cycle_done_q <= accept_cycle;
      if (accept_cycle) begin
        cycle_cnt_q <= cycle_cnt_q + 16'd1;
      end
    end
  end

  assign mon.cycle_done = cycle_done_q;
  assign mon.cycle_cnt  = cycle_cnt_q;
`endif

endmodule

// File: tb/tb_signal_monitor.sv
// Directed bench for signal_monitor with default parameters
// (MIN_DWELL 6, MAX_DWELL 12, YEL_MIN 1, YEL_MAX 3).
// Observation word: {locked, fault, fault_code[2:0], phase[1:0]}.
module tb_signal_monitor;

  localparam logic [1:0] R = 2'b00;
  localparam logic [1:0] Y = 2'b01;
  localparam logic [1:0] G = 2'b10;
  localparam logic [1:0] X = 2'b11;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  signal_monitor_if mon_if ();

  signal_monitor dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mon   (mon_if)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] snap();
    return {mon_if.locked, mon_if.fault, mon_if.fault_code, mon_if.phase};
  endfunction

  function automatic logic [6:0] st(input logic l, input logic f,
                                    input logic [2:0] c, input logic [1:0] p);
    return {l, f, c, p};
  endfunction

  // Drive one sample; returns 1 time unit after the edge that consumed it.
  task automatic tick(input logic [1:0] s, input logic c);
    mon_if.signal = s;
    mon_if.clr    = c;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [6:0] obs;
    rst_n         = 1'b0;
    mon_if.signal = R;
    mon_if.clr    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    obs = snap();
    checks++;
    if (obs !== st(0, 0, 3'd0, R)) begin
      errors++;
      $display("FAIL reset_state got %b want %b", obs, st(0, 0, 3'd0, R));
    end
    rst_n = 1'b1;
  endtask

  task automatic test_legal_seq();
    logic [6:0] obs;
    for (int i = 0; i < 7; i++) begin
      tick(R, 0);
      obs = snap();
      checks++;
      if (obs !== st(0, 0, 3'd0, R)) begin
        errors++;
        $display("FAIL legal_red%0d got %b want %b", i, obs, st(0, 0, 3'd0, R));
      end
    end
    tick(Y, 0);
    obs = snap();
    checks++;
    if (obs !== st(1, 0, 3'd0, Y)) begin
      errors++;
      $display("FAIL legal_yellow got %b want %b", obs, st(1, 0, 3'd0, Y));
    end
    for (int i = 0; i < 7; i++) begin
      tick(G, 0);
      obs = snap();
      checks++;
      if (obs !== st(1, 0, 3'd0, G)) begin
        errors++;
        $display("FAIL legal_green%0d got %b want %b", i, obs, st(1, 0, 3'd0, G));
      end
    end
    tick(R, 0);
    obs = snap();
    checks++;
    if (obs !== st(1, 0, 3'd0, R)) begin
      errors++;
      $display("FAIL legal_red_end got %b want %b", obs, st(1, 0, 3'd0, R));
    end
  endtask

  // Continues in TRACK with one RED edge already seen.
  task automatic test_dwell_short();
    logic [6:0] obs;
    for (int i = 0; i < 5; i++) tick(R, 0);
    tick(Y, 0);
    tick(Y, 0);
    obs = snap();
    checks++;
    if (obs !== st(1, 0, 3'd0, Y)) begin
      errors++;
      $display("FAIL short_yellow2 got %b want %b", obs, st(1, 0, 3'd0, Y));
    end
    for (int i = 0; i < 5; i++) tick(G, 0);
    obs = snap();
    checks++;
    if (obs !== st(1, 0, 3'd0, G)) begin
      errors++;
      $display("FAIL short_green5 got %b want %b", obs, st(1, 0, 3'd0, G));
    end
    tick(R, 0);
    obs = snap();
    checks++;
    if (obs !== st(0, 1, 3'd3, R)) begin
      errors++;
      $display("FAIL short_code3 got %b want %b", obs, st(0, 1, 3'd3, R));
    end
  endtask

  task automatic test_dwell_long();
    logic [6:0] obs;
    tick(R, 1);
    obs = snap();
    checks++;
    if (obs !== st(0, 0, 3'd0, R)) begin
      errors++;
      $display("FAIL long_clr got %b want %b", obs, st(0, 0, 3'd0, R));
    end
    tick(Y, 0);
    for (int i = 0; i < 6; i++) tick(G, 0);
    for (int k = 1; k <= 11; k++) begin
      tick(R, 0);
      obs = snap();
      checks++;
      if (obs !== st(1, 0, 3'd0, R)) begin
        errors++;
        $display("FAIL long_red%0d got %b want %b", k, obs, st(1, 0, 3'd0, R));
      end
    end
    tick(R, 0);
    obs = snap();
    checks++;
    if (obs !== st(0, 1, 3'd4, R)) begin
      errors++;
      $display("FAIL long_code4 got %b want %b", obs, st(0, 1, 3'd4, R));
    end
    tick(R, 0);
    tick(G, 0);
    obs = snap();
    checks++;
    if (obs !== st(0, 1, 3'd4, G)) begin
      errors++;
      $display("FAIL long_sticky got %b want %b", obs, st(0, 1, 3'd4, G));
    end
  endtask

  task automatic test_bad_transition();
    logic [6:0] obs;
    tick(R, 1);
    tick(Y, 0);
    for (int i = 0; i < 6; i++) tick(G, 0);
    tick(R, 0);
    obs = snap();
    checks++;
    if (obs !== st(1, 0, 3'd0, R)) begin
      errors++;
      $display("FAIL trans_red got %b want %b", obs, st(1, 0, 3'd0, R));
    end
    tick(G, 0);
    obs = snap();
    checks++;
    if (obs !== st(0, 1, 3'd2, G)) begin
      errors++;
      $display("FAIL trans_code2 got %b want %b", obs, st(0, 1, 3'd2, G));
    end
  endtask

  task automatic test_encoding_acq();
    logic [6:0] obs;
    tick(R, 1);
    for (int i = 0; i < 15; i++) tick(R, 0);
    obs = snap();
    checks++;
    if (obs !== st(0, 0, 3'd0, R)) begin
      errors++;
      $display("FAIL acq_no_timeout got %b want %b", obs, st(0, 0, 3'd0, R));
    end
    tick(X, 0);
    obs = snap();
    checks++;
    if (obs !== st(0, 1, 3'd1, R)) begin
      errors++;
      $display("FAIL acq_code1 got %b want %b", obs, st(0, 1, 3'd1, R));
    end
  endtask

  task automatic test_clr_priority();
    logic [6:0] obs;
    tick(X, 1);
    obs = snap();
    checks++;
    if (obs !== st(0, 0, 3'd0, R)) begin
      errors++;
      $display("FAIL clr_vs_code1 got %b want %b", obs, st(0, 0, 3'd0, R));
    end
    tick(R, 0);
    obs = snap();
    checks++;
    if (obs !== st(0, 0, 3'd0, R)) begin
      errors++;
      $display("FAIL clr_from_ill got %b want %b", obs, st(0, 0, 3'd0, R));
    end
    tick(Y, 0);
    obs = snap();
    checks++;
    if (obs !== st(1, 0, 3'd0, Y)) begin
      errors++;
      $display("FAIL clr_reacq got %b want %b", obs, st(1, 0, 3'd0, Y));
    end
    tick(R, 1);
    obs = snap();
    checks++;
    if (obs !== st(0, 0, 3'd0, R)) begin
      errors++;
      $display("FAIL clr_vs_code2 got %b want %b", obs, st(0, 0, 3'd0, R));
    end
    tick(Y, 0);
    obs = snap();
    checks++;
    if (obs !== st(1, 0, 3'd0, Y)) begin
      errors++;
      $display("FAIL clr_reacq2 got %b want %b", obs, st(1, 0, 3'd0, Y));
    end
  endtask

  task automatic test_async_reset();
    logic [6:0] obs;
    tick(G, 0);
    obs = snap();
    checks++;
    if (obs !== st(1, 0, 3'd0, G)) begin
      errors++;
      $display("FAIL areset_pre got %b want %b", obs, st(1, 0, 3'd0, G));
    end
    #2;
    rst_n = 1'b0;
    #1;
    obs = snap();
    checks++;
    if (obs !== st(0, 0, 3'd0, R)) begin
      errors++;
      $display("FAIL areset_async got %b want %b", obs, st(0, 0, 3'd0, R));
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(Y, 0);
    obs = snap();
    checks++;
    if (obs !== st(1, 0, 3'd0, Y)) begin
      errors++;
      $display("FAIL areset_history got %b want %b", obs, st(1, 0, 3'd0, Y));
    end
  endtask

`ifdef SIGMON_STATS_EN
  task automatic test_stats();
    int pulses;
    pulses = 0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    checks++;
    if (mon_if.cycle_cnt !== 16'd0) begin
      errors++;
      $display("FAIL stats_reset got %0d want 0", mon_if.cycle_cnt);
    end
    tick(R, 0);
    tick(Y, 0);
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < 6; i++) begin
        tick(G, 0);
        if (mon_if.cycle_done === 1'b1) pulses++;
      end
      tick(R, 0);
      checks++;
      if ({mon_if.cycle_done, mon_if.cycle_cnt} !== {1'b1, 16'(c + 1)}) begin
        errors++;
        $display("FAIL stats_cycle%0d got done=%b cnt=%0d want done=1 cnt=%0d",
                 c, mon_if.cycle_done, mon_if.cycle_cnt, c + 1);
      end
      if (mon_if.cycle_done === 1'b1) pulses++;
      for (int i = 0; i < 5; i++) begin
        tick(R, 0);
        if (mon_if.cycle_done === 1'b1) pulses++;
      end
      tick(Y, 0);
      if (mon_if.cycle_done === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 3) begin
      errors++;
      $display("FAIL stats_pulses got %0d want 3", pulses);
    end
    tick(R, 1);
    checks++;
    if (mon_if.cycle_cnt !== 16'd3) begin
      errors++;
      $display("FAIL stats_clr got %0d want 3", mon_if.cycle_cnt);
    end
  endtask
`endif

  initial begin
    mon_if.signal = R;
    mon_if.clr    = 1'b0;
    test_reset();
    test_legal_seq();
    test_dwell_short();
    test_dwell_long();
    test_bad_transition();
    test_encoding_acq();
    test_clr_priority();
    test_async_reset();
`ifdef SIGMON_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
